// File: rtl/gate_pkg.sv
// Shared definitions for the 2-input gate exerciser: op codes, FSM encoding and
// the reference truth table.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_APPLY  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StApply  = ST_APPLY,
    StSettle = ST_SETTLE,
    StCheck  = ST_CHECK,
    StDone   = ST_DONE
  } state_e;

  function automatic logic gate_expect(input logic [2:0] op, input logic a, input logic b);
    logic y;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the gate under test: expected output plus a flag
// telling whether the op code names a real gate.
module gate_ref_model
  import gate_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic       i_a,
  input  logic       i_b,
  output logic       o_expect,
  output logic       o_op_valid
);

  assign o_expect   = gate_expect(i_op, i_a, i_b);
  assign o_op_valid = (i_op <= OP_XNOR);

endmodule

// File: rtl/gate_exerciser.sv
// Drives a 2-input gate through all four input vectors, samples its output after
// a settle delay and reports per-vector mismatches against the selected function.
module gate_exerciser
  import gate_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op_sel,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_mask
);

  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);

  state_e     r_state, w_state_nxt;
  logic [2:0] r_op, w_op_nxt;
  logic [1:0] r_vec, w_vec_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_a, w_a_nxt;
  logic       r_b, w_b_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       r_pass, w_pass_nxt;
  logic [2:0] r_err, w_err_nxt;
  logic [3:0] r_mask, w_mask_nxt;

  logic [2:0] w_ref_op;
  logic       w_expect;
  logic       w_op_valid;

  // In IDLE the model judges the incoming op code; afterwards it uses the latched one.
  assign w_ref_op = (r_state == StIdle) ? op_sel : r_op;

  gate_ref_model u_ref (
    .i_op       (w_ref_op),
    .i_a        (r_a),
    .i_b        (r_b),
    .o_expect   (w_expect),
    .o_op_valid (w_op_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    w_err_nxt   = r_err;
    w_mask_nxt  = r_mask;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_op_nxt   = op_sel;
          w_err_nxt  = 3'd0;
          w_mask_nxt = 4'h0;
          w_pass_nxt = 1'b0;
          w_vec_nxt  = 2'd0;
          w_busy_nxt = 1'b1;
          w_a_nxt    = 1'b0;
          w_b_nxt    = 1'b0;
          if (w_op_valid) begin
            w_state_nxt = StApply;
          end else begin
            w_mask_nxt  = 4'hF;
            w_err_nxt   = 3'd4;
            w_done_nxt  = 1'b1;
            w_state_nxt = StDone;
          end
        end
      end
      StApply: begin
        w_cnt_nxt   = SettleLoad;
        w_state_nxt = StSettle;
      end
      StSettle: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = StCheck;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      StCheck: begin
        if (y_in != w_expect) begin
          w_err_nxt         = r_err + 3'd1;
          w_mask_nxt[r_vec] = 1'b1;
        end
        if (r_vec == 2'd3) begin
          w_pass_nxt  = (w_err_nxt == 3'd0);
          w_done_nxt  = 1'b1;
          w_state_nxt = StDone;
        end else begin
          w_vec_nxt   = r_vec + 2'd1;
          w_a_nxt     = w_vec_nxt[1];
          w_b_nxt     = w_vec_nxt[0];
          w_state_nxt = StApply;
        end
      end
      StDone: begin
        w_busy_nxt  = 1'b0;
        w_a_nxt     = 1'b0;
        w_b_nxt     = 1'b0;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_op    <= 3'd0;
      r_vec   <= 2'd0;
      r_cnt   <= 8'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 3'd0;
      r_mask  <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_vec   <= w_vec_nxt;
      r_cnt   <= w_cnt_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_err   <= w_err_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  assign a_out     = r_a;
  assign b_out     = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err;
  assign fail_mask = r_mask;

endmodule

// File: tb/tb_gate_exerciser.sv
// Scoreboard bench for gate_exerciser: stimulus pushes expected run results, a
// negedge monitor pops and compares them on every done pulse.
module tb_gate_exerciser;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op_sel;
  logic       a_out, b_out, y_in;
  logic       busy, done, pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_mask;

  int ymode;  // 0: behavioural NOR gate, 1: output stuck at 0

  assign y_in = (ymode == 0) ? ~(a_out | b_out) : 1'b0;

  gate_exerciser #(.SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_sel    (op_sel),
    .a_out     (a_out),
    .b_out     (b_out),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_mask (fail_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lat;   // done seen in the cycle ending at accept edge + lat
    logic       pass;
    logic [2:0] err;
    logic [3:0] mask;
    int         nvec;
    logic [7:0] seq;   // applied {a,b} sequence, vector i in bits [2i+1:2i]
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor
  logic       tracking = 1'b0;
  int         lat, seq_n;
  logic [7:0] seq;

  always @(negedge clk) begin
    if (rst) begin
      tracking = 1'b0;
    end else begin
      if (busy && !tracking) begin
        tracking = 1'b1;
        lat      = 1;
        seq_n    = 1;
        seq      = {6'd0, a_out, b_out};
      end else if (tracking) begin
        lat++;
        if ({a_out, b_out} != seq[2*seq_n-2 +: 2] && seq_n < 4) begin
          seq[2*seq_n +: 2] = {a_out, b_out};
          seq_n++;
        end else if ({a_out, b_out} != seq[2*seq_n-2 +: 2]) begin
          seq_n++;
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("latency", lat, e.lat);
          chk("busy_at_done", int'(busy), 1);
          chk("pass", int'(pass), int'(e.pass));
          chk("err_cnt", int'(err_cnt), int'(e.err));
          chk("fail_mask", int'(fail_mask), int'(e.mask));
          chk("vec_count", seq_n, e.nvec);
          chk("vec_seq", int'(seq), int'(e.seq));
        end
        tracking = 1'b0;
      end
    end
  end

  task automatic wait_done(input int base);
    for (int i = 0; i < 60 && done_cnt == base; i++) @(posedge clk);
    chk("done_timeout", done_cnt - base, 1);
  endtask

  task automatic run(input logic [2:0] op, input int ym, input logic ep,
                     input logic [2:0] ee, input logic [3:0] em, input logic disturb);
    exp_t e;
    int   base;
    logic ill;
    ill    = (op > 3'd5);
    e.lat  = ill ? 1 : 17;
    e.pass = ep;
    e.err  = ee;
    e.mask = em;
    e.nvec = ill ? 1 : 4;
    e.seq  = ill ? 8'h00 : 8'hE4;
    exp_q.push_back(e);
    base   = done_cnt;
    ymode  = ym;
    @(posedge clk); #1;
    op_sel = op;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    if (disturb) begin
      repeat (3) @(posedge clk);
      #1 op_sel = ~op;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 op_sel = 3'd0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(base);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    rst    = 1'b1;
    start  = 1'b0;
    op_sel = 3'd0;
    ymode  = 0;
    #1;
    chk("reset_outputs", int'({a_out, b_out, busy, done, pass, err_cnt, fail_mask}), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // op, y mode, pass, err_cnt, fail_mask, disturb
    run(3'd3, 0, 1'b1, 3'd0, 4'b0000, 1'b0);  // NOR on NOR
    repeat (3) @(posedge clk);
    chk("pass_held", int'(pass), 1);
    chk("idle_ab_zero", int'({a_out, b_out, busy}), 0);
    run(3'd0, 0, 1'b0, 3'd2, 4'b1001, 1'b0);  // AND on NOR
    run(3'd4, 1, 1'b0, 3'd2, 4'b0110, 1'b0);  // XOR on stuck-0
    run(3'd7, 0, 1'b0, 3'd4, 4'b1111, 1'b0);  // illegal op
    run(3'd6, 0, 1'b0, 3'd4, 4'b1111, 1'b0);  // illegal op
    run(3'd1, 0, 1'b0, 3'd4, 4'b1111, 1'b0);  // OR on NOR
    run(3'd5, 0, 1'b0, 3'd1, 4'b1000, 1'b0);  // XNOR on NOR
    run(3'd2, 0, 1'b0, 3'd2, 4'b0110, 1'b0);  // NAND on NOR
    run(3'd3, 0, 1'b1, 3'd0, 4'b0000, 1'b1);  // restart/op change ignored

    // Abort during SETTLE of vector 2
    ymode  = 0;
    base   = done_cnt;
    op_sel = 3'd3;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    for (int i = 0; i < 40 && !(a_out && !b_out); i++) begin
      @(posedge clk); #1;
    end
    chk("reached_vec2", int'({a_out, b_out}), 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        int'({a_out, b_out, busy, done, pass, err_cnt, fail_mask}), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (25) @(posedge clk);
    chk("no_done_after_abort", done_cnt - base, 0);
    run(3'd3, 0, 1'b1, 3'd0, 4'b0000, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
